// File: rtl/rc4_mem_decrypt.sv
// RC4 PRGA decryption engine: walks the keystream over an initialised S RAM,
// XORs it with the encrypted ROM and writes plaintext to the decrypted RAM.
module rc4_mem_decrypt #(
  parameter int MSG_MAX = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_sig,
  input  logic [7:0] q_data,
  input  logic [7:0] iterations,
  input  logic       valid_test,
  input  logic       other_finished,
  output logic       finish,
  output logic       decrypt_mem_handler,
  output logic [7:0] data,
  output logic [7:0] address,
  output logic [1:0] memory_sel,
  output logic       wen
);

  localparam logic [7:0] MSG_MAX_B = MSG_MAX[7:0];

  localparam logic [1:0] SEL_S   = 2'd0;
  localparam logic [1:0] SEL_ENC = 2'd1;
  localparam logic [1:0] SEL_DEC = 2'd2;

  typedef enum logic [4:0] {
    IDLE, INC_I, WAIT_SI, RD_SI, ADDR_SJ, WAIT_SJ, RD_SJ, WR_I, WR_J,
    ADDR_F, WAIT_F, RD_F, ADDR_E, WAIT_E, RD_E, WR_D, CHK, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
  logic [7:0] len_q, len_d;
  logic       finish_q, finish_d, handler_q, handler_d, wen_q, wen_d;
  logic [7:0] data_q, data_d, address_q, address_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] eff_len;
  logic       go_done;

  assign eff_len = (iterations > MSG_MAX_B) ? MSG_MAX_B : iterations;

  // Every memory read holds address for one wait state before q_data is captured.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    f_d       = f_q;
    enc_d     = enc_q;
    len_d     = len_q;
    finish_d  = finish_q;
    handler_d = handler_q;
    wen_d     = wen_q;
    data_d    = data_q;
    address_d = address_q;
    sel_d     = sel_q;
    go_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_sig) begin
          i_d   = 8'd0;
          j_d   = 8'd0;
          k_d   = 8'd0;
          len_d = eff_len;
          if (eff_len == 8'd0) begin
            go_done = 1'b1;
          end else begin
            handler_d = 1'b1;
            state_d   = INC_I;
          end
        end
      end
      INC_I: begin
        i_d       = i_q + 8'd1;
        address_d = i_q + 8'd1;
        sel_d     = SEL_S;
        state_d   = WAIT_SI;
      end
      WAIT_SI: state_d = RD_SI;
      RD_SI: begin
        si_d    = q_data;
        j_d     = j_q + q_data;
        state_d = ADDR_SJ;
      end
      ADDR_SJ: begin
        address_d = j_q;
        sel_d     = SEL_S;
        state_d   = WAIT_SJ;
      end
      WAIT_SJ: state_d = RD_SJ;
      RD_SJ: begin
        sj_d    = q_data;
        state_d = WR_I;
      end
      WR_I: begin
        address_d = i_q;
        data_d    = sj_q;
        wen_d     = 1'b1;
        state_d   = WR_J;
      end
      WR_J: begin
        address_d = j_q;
        data_d    = si_q;
        wen_d     = 1'b1;
        state_d   = ADDR_F;
      end
      ADDR_F: begin
        wen_d     = 1'b0;
        address_d = si_q + sj_q;
        sel_d     = SEL_S;
        state_d   = WAIT_F;
      end
      WAIT_F: state_d = RD_F;
      RD_F: begin
        f_d     = q_data;
        state_d = ADDR_E;
      end
      ADDR_E: begin
        sel_d     = SEL_ENC;
        address_d = k_q;
        state_d   = WAIT_E;
      end
      WAIT_E: state_d = RD_E;
      RD_E: begin
        enc_d   = q_data;
        state_d = WR_D;
      end
      WR_D: begin
        sel_d     = SEL_DEC;
        address_d = k_q;
        data_d    = f_q ^ enc_q;
        wen_d     = 1'b1;
        state_d   = CHK;
      end
      CHK: begin
        wen_d = 1'b0;
        if (!valid_test) begin
          go_done = 1'b1;
        end else begin
          k_d = k_q + 8'd1;
          if (k_q + 8'd1 == len_q) go_done = 1'b1;
          else                     state_d = INC_I;
        end
      end
      DONE: wen_d = 1'b0;
      default: state_d = IDLE;
    endcase

    // An abort suppresses whatever bus action this state would have issued.
    if (state_q != IDLE && state_q != DONE && other_finished) begin
      go_done   = 1'b1;
      data_d    = data_q;
      address_d = address_q;
      sel_d     = sel_q;
    end

    if (go_done) begin
      state_d   = DONE;
      finish_d  = 1'b1;
      handler_d = 1'b0;
      wen_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      k_q       <= 8'd0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      f_q       <= 8'd0;
      enc_q     <= 8'd0;
      len_q     <= 8'd0;
      finish_q  <= 1'b0;
      handler_q <= 1'b0;
      wen_q     <= 1'b0;
      data_q    <= 8'd0;
      address_q <= 8'd0;
      sel_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      f_q       <= f_d;
      enc_q     <= enc_d;
      len_q     <= len_d;
      finish_q  <= finish_d;
      handler_q <= handler_d;
      wen_q     <= wen_d;
      data_q    <= data_d;
      address_q <= address_d;
      sel_q     <= sel_d;
    end
  end

  assign finish              = finish_q;
  assign decrypt_mem_handler = handler_q;
  assign wen                 = wen_q;
  assign data                = data_q;
  assign address             = address_q;
  assign memory_sel          = sel_q;

endmodule

// File: tb/tb_rc4_mem_decrypt.sv
// Directed bench for rc4_mem_decrypt: models the S RAM, encrypted ROM and
// decrypted RAM, logs every write and checks traces against hand-computed values.
module tb_rc4_mem_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_sig;
  logic [7:0] q_data;
  logic [7:0] iterations;
  logic       valid_test;
  logic       other_finished;
  logic       finish;
  logic       decrypt_mem_handler;
  logic [7:0] data;
  logic [7:0] address;
  logic [1:0] memory_sel;
  logic       wen;

  logic [7:0]  sMem [256];
  logic [7:0]  rom [256];
  logic [17:0] writeLog [$];
  logic [18:0] busTrace [18];
  logic [1:0]  statusTrace [18];

  int assertCount = 0;
  int failCount   = 0;

  rc4_mem_decrypt #(.MSG_MAX(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_sig           (start_sig),
    .q_data              (q_data),
    .iterations          (iterations),
    .valid_test          (valid_test),
    .other_finished      (other_finished),
    .finish              (finish),
    .decrypt_mem_handler (decrypt_mem_handler),
    .data                (data),
    .address             (address),
    .memory_sel          (memory_sel),
    .wen                 (wen)
  );

  always #5 clk = ~clk;

  // Memory read data follows the registered address combinationally.
  assign q_data = (memory_sel == 2'd0) ? sMem[address] :
                  (memory_sel == 2'd1) ? rom[address] : 8'h00;

  // Every write is logged; writes to the S RAM also update the model.
  always @(posedge clk) begin
    if (wen) begin
      writeLog.push_back({memory_sel, address, data});
      if (memory_sel == 2'd0) sMem[address] <= data;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Fills S and ROM with either all-ones or an identity S plus an "ABC" ciphertext.
  task automatic initMem(input bit identity);
    for (int n = 0; n < 256; n++) begin
      sMem[n] = identity ? n[7:0] : 8'h01;
      rom[n]  = 8'h01;
    end
    if (identity) begin
      rom[0] = 8'h43;
      rom[1] = 8'h47;
      rom[2] = 8'h44;
    end
  endtask

  task automatic doReset();
    reset          = 1'b1;
    start_sig      = 1'b0;
    other_finished = 1'b0;
    valid_test     = 1'b1;
    iterations     = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    writeLog.delete();
  endtask

  // Drives start for exactly one rising edge and returns on the following negedge.
  task automatic applyStimulus(input logic [7:0] iter);
    iterations = iter;
    start_sig  = 1'b1;
    @(negedge clk);
    start_sig  = 1'b0;
  endtask

  task automatic runToFinish(input int budget, output int cycles);
    cycles = 1;
    while (!finish && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic int countDecWrites();
    int cnt = 0;
    foreach (writeLog[n]) if (writeLog[n][17:16] == 2'd2) cnt++;
    return cnt;
  endfunction

  // One-byte run with S and ROM all ones; captures the bus after edges 1..17.
  task automatic runScenario1(input string pfx);
    initMem(1'b0);
    applyStimulus(8'd1);
    busTrace[1]    = {wen, memory_sel, address, data};
    statusTrace[1] = {finish, decrypt_mem_handler};
    for (int n = 2; n <= 17; n++) begin
      @(negedge clk);
      busTrace[n]    = {wen, memory_sel, address, data};
      statusTrace[n] = {finish, decrypt_mem_handler};
    end
    checkOutput({pfx, " status after start"}, 32'(statusTrace[1]), 32'b01);
    checkOutput({pfx, " read S[i]"},  32'(busTrace[2][18:8]),  {21'd0, 1'b0, 2'd0, 8'd1});
    checkOutput({pfx, " read S[j]"},  32'(busTrace[5][18:8]),  {21'd0, 1'b0, 2'd0, 8'd1});
    checkOutput({pfx, " swap wr i"},  32'(busTrace[8]),  {13'd0, 1'b1, 2'd0, 8'd1, 8'd1});
    checkOutput({pfx, " swap wr j"},  32'(busTrace[9]),  {13'd0, 1'b1, 2'd0, 8'd1, 8'd1});
    checkOutput({pfx, " read f"},     32'(busTrace[10][18:8]), {21'd0, 1'b0, 2'd0, 8'd2});
    checkOutput({pfx, " read enc"},   32'(busTrace[13][18:8]), {21'd0, 1'b0, 2'd1, 8'd0});
    checkOutput({pfx, " dec write"},  32'(busTrace[16]), {13'd0, 1'b1, 2'd2, 8'd0, 8'd0});
    checkOutput({pfx, " status at 16"}, 32'(statusTrace[16]), 32'b01);
    checkOutput({pfx, " status at 17"}, 32'(statusTrace[17]), 32'b10);
    checkOutput({pfx, " bus held in done"}, 32'(busTrace[17]), {13'd0, 1'b0, 2'd2, 8'd0, 8'd0});
    checkOutput({pfx, " write count"}, 32'(writeLog.size()), 32'd3);
    if (writeLog.size() == 3) begin
      checkOutput({pfx, " log 0"}, 32'(writeLog[0]), {14'd0, 2'd0, 8'd1, 8'd1});
      checkOutput({pfx, " log 1"}, 32'(writeLog[1]), {14'd0, 2'd0, 8'd1, 8'd1});
      checkOutput({pfx, " log 2"}, 32'(writeLog[2]), {14'd0, 2'd2, 8'd0, 8'd0});
    end
  endtask

  logic [17:0] expLog [9];

  initial begin
    int cycles;

    // Scenario 1: single byte, constant memory contents
    doReset();
    checkOutput("reset outputs", {19'd0, finish, decrypt_mem_handler, wen, memory_sel, address},
                32'd0);
    runScenario1("s1");

    // Scenario 2: release reset with start held and abort pending
    reset          = 1'b1;
    start_sig      = 1'b1;
    other_finished = 1'b1;
    iterations     = 8'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    writeLog.delete();
    repeat (2) @(negedge clk);
    checkOutput("abort finish", 32'(finish), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("abort sticky", {30'd0, finish, decrypt_mem_handler}, 32'b10);
    checkOutput("abort no writes", 32'(writeLog.size()), 32'd0);

    // Scenario 3: three bytes over identity S, plaintext "ABC"
    doReset();
    initMem(1'b1);
    applyStimulus(8'd3);
    runToFinish(200, cycles);
    checkOutput("3 byte latency", 32'(cycles), 32'd49);
    expLog[0] = {2'd0, 8'd1, 8'd1};
    expLog[1] = {2'd0, 8'd1, 8'd1};
    expLog[2] = {2'd2, 8'd0, 8'h41};
    expLog[3] = {2'd0, 8'd2, 8'd3};
    expLog[4] = {2'd0, 8'd3, 8'd2};
    expLog[5] = {2'd2, 8'd1, 8'h42};
    expLog[6] = {2'd0, 8'd3, 8'd5};
    expLog[7] = {2'd0, 8'd5, 8'd2};
    expLog[8] = {2'd2, 8'd2, 8'h43};
    checkOutput("3 byte write count", 32'(writeLog.size()), 32'd9);
    if (writeLog.size() == 9) begin
      for (int n = 0; n < 9; n++)
        checkOutput($sformatf("3 byte log %0d", n), 32'(writeLog[n]), 32'(expLog[n]));
    end

    // Scenario 4: plaintext rejected at the first check
    doReset();
    initMem(1'b1);
    valid_test = 1'b0;
    applyStimulus(8'd3);
    runToFinish(200, cycles);
    checkOutput("invalid latency", 32'(cycles), 32'd17);
    checkOutput("invalid dec writes", 32'(countDecWrites()), 32'd1);
    if (writeLog.size() == 3)
      checkOutput("invalid dec addr", 32'(writeLog[2][15:8]), 32'd0);
    else
      checkOutput("invalid write count", 32'(writeLog.size()), 32'd3);

    // Scenario 5: asynchronous reset while waiting on S[j], then rerun scenario 1
    doReset();
    initMem(1'b0);
    applyStimulus(8'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async reset", {19'd0, finish, decrypt_mem_handler, wen, memory_sel, address},
                32'd0);
    checkOutput("async reset data", 32'(data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    writeLog.delete();
    runScenario1("s5");

    // Scenario 6: zero length finishes immediately without touching memory
    doReset();
    applyStimulus(8'd0);
    checkOutput("zero len finish", {30'd0, finish, decrypt_mem_handler}, 32'b10);
    repeat (3) @(negedge clk);
    checkOutput("zero len no access", 32'(writeLog.size()), 32'd0);

    // Clamp: a length above MSG_MAX decrypts exactly MSG_MAX bytes
    doReset();
    initMem(1'b1);
    applyStimulus(8'd40);
    runToFinish(1000, cycles);
    checkOutput("clamp latency", 32'(cycles), 32'd513);
    checkOutput("clamp dec writes", 32'(countDecWrites()), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
